// File: rtl/cdc_pkg.sv
// rtl/cdc_pkg.sv - shared state type and defaults for the CDC handshake source
package cdc_pkg;

  typedef enum logic {
    IDLE     = 1'b0,
    WAIT_ACK = 1'b1
  } tx_state_t;

  localparam int CDC_SYNC_STAGES = 2;

endpackage

// File: rtl/sync_bit.sv
// rtl/sync_bit.sv - N-stage single-bit synchronizer, synchronous reset to 0
module sync_bit #(
  parameter int STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);

  // Only the first flop can go metastable; it is kept apart so tools place it tightly.
  (* ASYNC_REG = "TRUE" *) logic meta_q;
  logic [STAGES-2:0] tail_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      meta_q <= 1'b0;
      tail_q <= '0;
    end else begin
      meta_q    <= d_i;
      tail_q[0] <= meta_q;
      for (int i = 1; i < STAGES - 1; i++) begin
        tail_q[i] <= tail_q[i-1];
      end
    end
  end

  assign q_o = tail_q[STAGES-2];

endmodule

// File: rtl/cdc_handshake_tx.sv
// rtl/cdc_handshake_tx.sv - source side of a two-phase req/ack multibit crossing
module cdc_handshake_tx
  import cdc_pkg::*;
#(
  parameter int NB          = 8,
  parameter int SYNC_STAGES = CDC_SYNC_STAGES,
  parameter int CNT_W       = 16
) (
  input  logic             i_clock,
  input  logic             i_reset,
  input  logic             i_valid,
  input  logic [NB-1:0]    i_data,
  output logic             o_ready,
  output logic [NB-1:0]    o_data,
  output logic             o_req,
  input  logic             i_ack,
  output logic             o_error,
  output logic [CNT_W-1:0] o_xfer_count
);

  tx_state_t        state_q;
  logic [NB-1:0]    data_q;
  logic             req_q;
  logic             err_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             ack_s;

  sync_bit #(
    .STAGES(SYNC_STAGES)
  ) u_ack_sync (
    .clk_i(i_clock),
    .rst_i(i_reset),
    .d_i  (i_ack),
    .q_o  (ack_s)
  );

  assign cnt_d = cnt_q + CNT_W'(1);

  // The transfer is done once the synchronized ack parity catches up with req.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_q <= IDLE;
      data_q  <= '0;
      req_q   <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (ack_s != req_q) begin
            err_q <= 1'b1;
          end
          if (i_valid) begin
            data_q  <= i_data;
            req_q   <= ~req_q;
            state_q <= WAIT_ACK;
          end
        end
        WAIT_ACK: begin
          if (ack_s == req_q) begin
            cnt_q   <= cnt_d;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign o_ready      = (state_q == IDLE) && !i_reset;
  assign o_data       = data_q;
  assign o_req        = req_q;
  assign o_error      = err_q;
  assign o_xfer_count = cnt_q;

endmodule

// File: tb/tb_cdc_handshake_tx.sv
// tb/tb_cdc_handshake_tx.sv - directed bench for the CDC handshake source
module tb_cdc_handshake_tx;

  logic        clk = 1'b0;
  logic        dclk = 1'b0;
  logic        rst = 1'b1;
  logic        valid = 1'b0;
  logic [7:0]  data = 8'h00;
  logic        man_ack = 1'b0;
  logic        dest_en = 1'b0;
  logic        ack_w;
  logic        ready;
  logic [7:0]  odata;
  logic        req;
  logic        err;
  logic [15:0] cnt;

  logic        ds1 = 1'b0;
  logic        ds2 = 1'b0;
  logic        dest_ack = 1'b0;
  logic [7:0]  cap[$];

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;
  always begin
    #3 dclk = 1'b1;
    #4 dclk = 1'b0;
  end

  assign ack_w = dest_en ? dest_ack : man_ack;

  cdc_handshake_tx #(
    .NB(8),
    .SYNC_STAGES(2),
    .CNT_W(16)
  ) dut (
    .i_clock     (clk),
    .i_reset     (rst),
    .i_valid     (valid),
    .i_data      (data),
    .o_ready     (ready),
    .o_data      (odata),
    .o_req       (req),
    .i_ack       (ack_w),
    .o_error     (err),
    .o_xfer_count(cnt)
  );

  // Destination: synchronize req, capture the bus on each new toggle, echo it back as ack.
  always @(posedge dclk) begin
    ds1 <= req;
    ds2 <= ds1;
    dest_ack <= ds2;
    if (dest_en && ds2 != dest_ack) cap.push_back(odata);
  end

  task automatic test_reset();
    rst = 1'b1; valid = 1'b1; data = 8'h77; man_ack = 1'b0; dest_en = 1'b0;
    repeat (3) @(negedge clk);
    total++; if (ready !== 1'b0) begin bad++; $display("FAIL reset_ready got=%b exp=0", ready); end
    total++; if (req !== 1'b0) begin bad++; $display("FAIL reset_req got=%b exp=0", req); end
    total++; if (odata !== 8'h00) begin bad++; $display("FAIL reset_data got=%h exp=00", odata); end
    total++; if (cnt !== 16'd0) begin bad++; $display("FAIL reset_count got=%0d exp=0", cnt); end
    total++; if (err !== 1'b0) begin bad++; $display("FAIL reset_error got=%b exp=0", err); end
    rst = 1'b0; valid = 1'b0;
    #1;
    total++; if (ready !== 1'b1) begin bad++; $display("FAIL release_ready got=%b exp=1", ready); end
    @(negedge clk);
    total++; if (ready !== 1'b1) begin bad++; $display("FAIL first_cycle_ready got=%b exp=1", ready); end
  endtask

  task automatic test_single();
    data = 8'hA5; valid = 1'b1;
    @(negedge clk);
    valid = 1'b0; data = 8'h00;
    total++; if (odata !== 8'hA5) begin bad++; $display("FAIL single_data got=%h exp=a5", odata); end
    total++; if (req !== 1'b1) begin bad++; $display("FAIL single_req got=%b exp=1", req); end
    total++; if (ready !== 1'b0) begin bad++; $display("FAIL single_busy got=%b exp=0", ready); end
    repeat (3) @(negedge clk);
    total++; if (ready !== 1'b0) begin bad++; $display("FAIL single_wait got=%b exp=0", ready); end
    man_ack = 1'b1;
    repeat (2) @(negedge clk);
    total++; if (ready !== 1'b0 || cnt !== 16'd0) begin bad++; $display("FAIL single_k1 ready=%b cnt=%0d exp ready=0 cnt=0", ready, cnt); end
    @(negedge clk);
    total++; if (ready !== 1'b1 || cnt !== 16'd1) begin bad++; $display("FAIL single_k2 ready=%b cnt=%0d exp ready=1 cnt=1", ready, cnt); end
    total++; if (err !== 1'b0) begin bad++; $display("FAIL single_error got=%b exp=0", err); end
  endtask

  task automatic test_backpressure();
    logic [7:0] noise[4] = '{8'h11, 8'h22, 8'h33, 8'h44};
    int held_bad = 0;
    data = 8'h3C; valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      data = noise[i];
      if (odata !== 8'h3C || ready !== 1'b0) held_bad++;
    end
    man_ack = 1'b0;
    data = 8'h55;
    repeat (2) @(negedge clk);
    if (odata !== 8'h3C) held_bad++;
    total++; if (held_bad != 0) begin bad++; $display("FAIL bp_hold errors=%0d exp=0", held_bad); end
    @(negedge clk);
    total++; if (ready !== 1'b1 || odata !== 8'h3C || cnt !== 16'd2) begin bad++; $display("FAIL bp_done ready=%b data=%h cnt=%0d exp 1/3c/2", ready, odata, cnt); end
    @(negedge clk);
    valid = 1'b0;
    total++; if (odata !== 8'h55 || req !== 1'b1 || ready !== 1'b0) begin bad++; $display("FAIL bp_next data=%h req=%b ready=%b exp 55/1/0", odata, req, ready); end
    man_ack = 1'b1;
    repeat (3) @(negedge clk);
    total++; if (ready !== 1'b1 || cnt !== 16'd3) begin bad++; $display("FAIL bp_final ready=%b cnt=%0d exp 1/3", ready, cnt); end
  endtask

  task automatic test_spurious();
    man_ack = 1'b0;
    repeat (2) @(negedge clk);
    total++; if (err !== 1'b0) begin bad++; $display("FAIL spur_early got=%b exp=0", err); end
    @(negedge clk);
    total++; if (err !== 1'b1) begin bad++; $display("FAIL spur_set got=%b exp=1", err); end
    data = 8'h99; valid = 1'b1;
    @(negedge clk);
    valid = 1'b0;
    @(negedge clk);
    total++; if (ready !== 1'b1 || cnt !== 16'd4 || err !== 1'b1) begin bad++; $display("FAIL spur_xfer1 ready=%b cnt=%0d err=%b exp 1/4/1", ready, cnt, err); end
    data = 8'h42; valid = 1'b1;
    @(negedge clk);
    valid = 1'b0;
    man_ack = 1'b1;
    repeat (3) @(negedge clk);
    total++; if (odata !== 8'h42 || cnt !== 16'd5 || err !== 1'b1) begin bad++; $display("FAIL spur_xfer2 data=%h cnt=%0d err=%b exp 42/5/1", odata, cnt, err); end
  endtask

  task automatic test_reset_wait();
    data = 8'h5A; valid = 1'b1;
    @(negedge clk);
    valid = 1'b0;
    total++; if (odata !== 8'h5A || ready !== 1'b0) begin bad++; $display("FAIL rw_accept data=%h ready=%b exp 5a/0", odata, ready); end
    @(negedge clk);
    rst = 1'b1; man_ack = 1'b0;
    @(negedge clk);
    total++; if (req !== 1'b0 || odata !== 8'h00 || err !== 1'b0 || cnt !== 16'd0) begin bad++; $display("FAIL rw_reset req=%b data=%h err=%b cnt=%0d exp 0/00/0/0", req, odata, err, cnt); end
    rst = 1'b0;
    @(negedge clk);
    total++; if (ready !== 1'b1 || req !== 1'b0) begin bad++; $display("FAIL rw_release ready=%b req=%b exp 1/0", ready, req); end
    repeat (3) @(negedge clk);
    total++; if (err !== 1'b0 || ready !== 1'b1) begin bad++; $display("FAIL rw_idle err=%b ready=%b exp 0/1", err, ready); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] seq[3] = '{8'h01, 8'h02, 8'h03};
    int idx = 0;
    int cyc = 0;
    int unstable = 0;
    logic prev_ready;
    logic [7:0] prev_data;
    repeat (6) @(negedge clk);
    cap.delete();
    dest_en = 1'b1;
    prev_ready = ready;
    prev_data = odata;
    while ((idx < 3 || cnt !== 16'd3 || ready !== 1'b1) && cyc < 300) begin
      if (ready && idx < 3) begin
        data = seq[idx]; valid = 1'b1; idx++;
      end else if (!ready) begin
        data = ~data;
      end
      @(negedge clk);
      cyc++;
      if (!prev_ready && odata !== prev_data) unstable++;
      prev_ready = ready;
      prev_data = odata;
    end
    valid = 1'b0;
    repeat (5) @(negedge clk);
    total++; if (cyc >= 300) begin bad++; $display("FAIL b2b_timeout cycles=%0d limit=300", cyc); end
    total++; if (unstable != 0) begin bad++; $display("FAIL b2b_stable changes=%0d exp=0", unstable); end
    total++; if (cap.size() != 3 || {cap[0], cap[1], cap[2]} !== 24'h010203) begin bad++; $display("FAIL b2b_capture n=%0d exp 3 words 01 02 03", cap.size()); end
    total++; if (cnt !== 16'd3 || err !== 1'b0) begin bad++; $display("FAIL b2b_count cnt=%0d err=%b exp 3/0", cnt, err); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_backpressure();
    test_spurious();
    test_reset_wait();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
